ws2812_rx: RTL and testbench
============================

// Module: ws2812_rx
// PURPOSE
//  Receive side of the WS2812 single-wire LED protocol: samples a serial line driven by a
//  PIO side-set pin (or a real LED chain's DOUT) and decodes it into BITS-wide GRB words.
//  Pulse widths are measured in clk cycles. Data is MSB first. A long low gap marks the
//  latch/reset. Words go out on a valid/ready stream. Used as the loopback checker for PIO
//  WS2812 programs and for daisy-chain pass-through.
// PARAMETERS
//  BITS      24    bits per word (GRB); 1..32
//  T_MIN     3     min legal high time, cycles; shorter -> glitch
//  T_THRESH  15    high >= T_THRESH decodes 1, else 0 (25MHz: 0.6us)
//  T_MAX     40    high >= T_MAX -> stuck-high error
//  T_RESET   1250  low >= T_RESET -> latch/frame end (25MHz: 50us)
// PORTS
//  clk         in   1     system clock
//  reset       in   1     asynchronous, active-low reset
//  enable      in   1     0: hold in IDLE, discard partial word, no errors raised
//  din         in   1     serial line; asynchronous; 2-flop synchronised internally
//  rx_data     out  BITS  decoded word, first received bit at MSB
//  rx_valid    out  1     word available; held until accepted
//  rx_ready    in   1     consumer accept; transfer when rx_valid && rx_ready
//  frame_end   out  1     1-cycle pulse when a latch gap is detected
//  err_glitch  out  1     sticky: high pulse < T_MIN
//  err_long    out  1     sticky: high pulse >= T_MAX
//  err_partial out  1     sticky: latch gap with 0 < bit count < BITS
//  err_ovf     out  1     sticky: word completed while storage full (word dropped)
//  err_clr     in   1     clears all sticky errors; a same-cycle set wins
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0, state IDLE, counters 0, storage empty, sync flops 0.
//  Front end: din -> 2 sync flops -> edge-detect register. A pin edge is seen by the FSM
//   3 clk later. Counters are 16-bit and saturate at 16'hFFFF.
//  FSM:
//   IDLE : wait for rising edge; cnt<=1 -> HIGH.
//   HIGH : cnt++. Falling edge: cnt<T_MIN -> err_glitch, no bit; else shift in (cnt>=T_THRESH),
//          bitcnt++; cnt<=1 -> LOW. cnt reaches T_MAX -> err_long, discard partial -> STUCK.
//   LOW  : cnt++. Rising edge -> HIGH (cnt<=1). cnt reaches T_RESET -> frame_end pulse;
//          bitcnt!=0 -> err_partial, discard; bitcnt<=0 -> IDLE.
//   STUCK: wait for falling edge -> LOW (cnt<=1). The latch gap then resynchronises.
//  Word complete: bitcnt==BITS after a shift -> word pushed, rx_valid is high the cycle after
//   the falling edge is decoded, bitcnt<=0. The shift register resets to 0 per word.
//  Handshake: rx_data stable while rx_valid && !rx_ready. Push on full storage -> drop new
//   word, set err_ovf. A push and a pop in the same cycle on full storage is legal (no ovf).
//  enable falling mid-word: partial discarded silently, -> IDLE. Stored words are kept.
//  enable rising while din high: wait in IDLE for the next rising edge (no mid-pulse decode).
// CONFIGURATION
//  WS2812_RX_FIFO_EN defined: 4-entry output FIFO. rx_valid = !empty. Overflow only when
//   4 words are unread.
//  Undefined: single holding register. rx_valid clears on accept. Overflow if a second
//   word completes before accept.
//  All other behaviour is identical.
// TESTING (25MHz clk, default params; '1'=20 high/10 low, '0'=8 high/22 low cycles)
//  1. 0xFF00FF then 1300 low, rx_ready=1 -> rx_data=24'hFF00FF once, frame_end once, no errors.
//  2. 3 words 0x123456,0xABCDEF,0x000001 back-to-back, rx_ready=0 until frame_end -> FIFO_EN:
//     all 3 in order, err_ovf=0; no FIFO: 0x123456 held, err_ovf=1.
//  3. 2-cycle high pulse mid-word then 24 good bits 0x00F0F0 -> err_glitch=1, rx_data=24'h00F0F0.
//  4. 12 bits then 1300 low -> err_partial=1, frame_end pulse, rx_valid=0; err_clr -> flags 0.
//  5. din held high 100 cycles, low 1300, then 0x5A5A5A -> err_long=1, next word 24'h5A5A5A.
//  6. Assert reset=0 after 10 bits, release, send 0x800000 -> all outputs 0 in reset, word 24'h800000.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Measures high/low pulse widths in clk
// cycles, decodes BITS-wide MSB-first words and emits them on a valid/ready stream.
// Optional build macro WS2812_RX_FIFO_EN selects a 4-entry output FIFO; without it a
// single holding register is used.
//
// Handshake: rx_valid stays high, and rx_data stays stable, until the cycle in which
// rx_valid && rx_ready is seen on a rising clk edge; that edge is the transfer.
module ws2812_rx #(
    parameter int BITS     = 24,
    parameter int T_MIN    = 3,
    parameter int T_THRESH = 15,
    parameter int T_MAX    = 40,
    parameter int T_RESET  = 1250
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            din,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_end,
    output logic            err_glitch,
    output logic            err_long,
    output logic            err_partial,
    output logic            err_ovf,
    input  logic            err_clr,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_STUCK = 2'd3
    } state_e;

    logic sync1_q, sync2_q, prev_q;
    logic rise, fall;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d, cnt_inc;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic [BITS-1:0] shreg_q, shreg_d, shift_val;
    logic            bit_val;
    logic            frame_end_q, frame_end_d;
    logic            set_glitch, set_long, set_partial, set_ovf;
    logic            err_glitch_q, err_long_q, err_partial_q, err_ovf_q;
    logic            push, pop;

    // Two-flop synchroniser followed by the edge-detect register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign bit_val   = (cnt_q >= 16'(T_THRESH));
    assign shift_val = (shreg_q << 1) | BITS'(bit_val);

    // Decoder state, counters, shift register and pulse/sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            bitcnt_q      <= 6'd0;
            shreg_q       <= '0;
            frame_end_q   <= 1'b0;
            err_glitch_q  <= 1'b0;
            err_long_q    <= 1'b0;
            err_partial_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            frame_end_q   <= frame_end_d;
            // A set in the same cycle as a clear wins
            err_glitch_q  <= set_glitch  | (err_glitch_q  & ~err_clr);
            err_long_q    <= set_long    | (err_long_q    & ~err_clr);
            err_partial_q <= set_partial | (err_partial_q & ~err_clr);
            err_ovf_q     <= set_ovf     | (err_ovf_q     & ~err_clr);
        end
    end

    // Next-state decode: pulse classification, bit shifting and word completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        frame_end_d = 1'b0;
        set_glitch  = 1'b0;
        set_long    = 1'b0;
        set_partial = 1'b0;
        push        = 1'b0;
        if (!enable) begin
            // Disabled: drop any partial word, raise nothing
            state_d  = S_IDLE;
            cnt_d    = 16'd0;
            bitcnt_d = 6'd0;
            shreg_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        cnt_d   = 16'd1;
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        if (cnt_q < 16'(T_MIN)) begin
                            set_glitch = 1'b1;
                        end else if (bitcnt_q + 6'd1 == 6'(BITS)) begin
                            push     = 1'b1;
                            bitcnt_d = 6'd0;
                            shreg_d  = '0;
                        end else begin
                            shreg_d  = shift_val;
                            bitcnt_d = bitcnt_q + 6'd1;
                        end
                        cnt_d   = 16'd1;
                        state_d = S_LOW;
                    end else if (cnt_inc >= 16'(T_MAX)) begin
                        set_long = 1'b1;
                        bitcnt_d = 6'd0;
                        shreg_d  = '0;
                        cnt_d    = 16'd0;
                        state_d  = S_STUCK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        cnt_d   = 16'd1;
                        state_d = S_HIGH;
                    end else if (cnt_inc >= 16'(T_RESET)) begin
                        frame_end_d = 1'b1;
                        set_partial = (bitcnt_q != 6'd0);
                        bitcnt_d    = 6'd0;
                        shreg_d     = '0;
                        cnt_d       = 16'd0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_STUCK: begin
                    // Wait out the stuck-high line; the following latch gap resyncs
                    if (fall) begin
                        cnt_d   = 16'd1;
                        state_d = S_LOW;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef WS2812_RX_FIFO_EN
    logic [BITS-1:0] mem_q [0:3];
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      count_q;
    logic            full, accept;

    assign full    = (count_q == 3'd4);
    assign pop     = rx_valid & rx_ready;
    assign accept  = push & (~full | pop);
    assign set_ovf = push & full & ~pop;

    // Four-entry output FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= shift_val;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, accept} - {2'b00, pop};
        end
    end

    assign rx_data  = mem_q[rd_ptr_q];
    assign rx_valid = (count_q != 3'd0);
`else
    logic [BITS-1:0] hold_q;
    logic            valid_q, accept;

    assign pop     = valid_q & rx_ready;
    assign accept  = push & (~valid_q | pop);
    assign set_ovf = push & valid_q & ~pop;

    // Single holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                hold_q  <= shift_val;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = valid_q;
`endif

    assign frame_end   = frame_end_q;
    assign err_glitch  = err_glitch_q;
    assign err_long    = err_long_q;
    assign err_partial = err_partial_q;
    assign err_ovf     = err_ovf_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives WS2812 waveforms into ws2812_rx and checks decoded words,
// frame_end pulses and sticky error flags against a pulse-width model.
module tb_ws2812_rx;
    localparam int BITS     = 24;
    localparam int T_THRESH = 15;
`ifdef WS2812_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic            clk = 1'b0;
    logic            reset, enable, din, rx_ready, err_clr;
    logic [BITS-1:0] rx_data;
    logic            rx_valid, frame_end, err_glitch, err_long, err_partial, err_ovf;
    logic [1:0]      dbg_state;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              fe_cnt   = 0;
    bit              rand_ready_en = 1'b0;
    logic [BITS-1:0] got_q[$];
    logic [BITS-1:0] exp_q[$];

    ws2812_rx dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_end(frame_end), .err_glitch(err_glitch), .err_long(err_long),
        .err_partial(err_partial), .err_ovf(err_ovf), .err_clr(err_clr),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #20 clk = ~clk;

    // scoreboard capture: transfers and frame_end pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_end) fe_cnt++;
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_ready_en) rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        din = 1'b1;
        step(hi);
        din = 1'b0;
        step(lo);
    endtask

    task automatic send_word(input logic [BITS-1:0] w, input int nbits);
        logic [BITS-1:0] tmp;
        tmp = w;
        for (int i = 0; i < nbits; i++) begin
            if (tmp[BITS-1-i]) send_bit(1'b1, 20, 10);
            else               send_bit(1'b0, 8, 22);
        end
    endtask

    task automatic latch_gap();
        din = 1'b0;
        step(1300);
    endtask

    task automatic clear_state();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
        got_q.delete();
        exp_q.delete();
        fe_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; din = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        step(3);
        n_checks++;
        if (rx_data !== '0) begin n_fail++; $display("FAIL reset rx_data: got %h expected 0", rx_data); end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset rx_valid: got %b expected 0", rx_valid); end
        n_checks++;
        if (frame_end !== 1'b0) begin n_fail++; $display("FAIL reset frame_end: got %b expected 0", frame_end); end
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL reset errors: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        clear_state();
        rx_ready = 1'b1;
        send_word(24'hFF00FF, BITS);
        latch_gap();
        step(5);
        exp_q.push_back(24'hFF00FF);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++;
        if (fe_cnt != 1) begin n_fail++; $display("FAIL basic frame_end count: got %0d expected 1", fe_cnt); end
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL basic errors: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] words [3];
        int kept;
        words = '{24'h123456, 24'hABCDEF, 24'h000001};
        clear_state();
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(words[i], BITS);
        latch_gap();
        kept = (3 < DEPTH) ? 3 : DEPTH;
        for (int i = 0; i < kept; i++) exp_q.push_back(words[i]);
        n_checks++;
        if (err_ovf !== (3 > DEPTH)) begin n_fail++; $display("FAIL b2b err_ovf: got %b expected %b", err_ovf, (3 > DEPTH)); end
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== words[0]) begin
            n_fail++; $display("FAIL b2b head: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, words[0]);
        end
        step(20);
        n_checks++;
        if (rx_data !== words[0]) begin n_fail++; $display("FAIL b2b hold stable: got %h expected %h", rx_data, words[0]); end
        rx_ready = 1'b1;
        step(10);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drained valid: got %b expected 0", rx_valid); end
        n_checks++;
        if (fe_cnt != 1) begin n_fail++; $display("FAIL b2b frame_end count: got %0d expected 1", fe_cnt); end
    endtask

    task automatic test_glitch();
        clear_state();
        rx_ready = 1'b1;
        din = 1'b1; step(2);
        din = 1'b0; step(20);
        send_word(24'h00F0F0, BITS);
        latch_gap();
        step(5);
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b1000) begin
            n_fail++; $display("FAIL glitch errors: got %b expected 1000", {err_glitch, err_long, err_partial, err_ovf});
        end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL glitch count: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== 24'h00F0F0) begin
            n_fail++; $display("FAIL glitch word: got %h expected 00f0f0", got_q[0]);
        end
    endtask

    task automatic test_partial();
        clear_state();
        rx_ready = 1'b1;
        send_word(24'hABC000, 12);
        latch_gap();
        step(5);
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0010) begin
            n_fail++; $display("FAIL partial errors: got %b expected 0010", {err_glitch, err_long, err_partial, err_ovf});
        end
        n_checks++;
        if (fe_cnt != 1) begin n_fail++; $display("FAIL partial frame_end count: got %0d expected 1", fe_cnt); end
        n_checks++;
        if (rx_valid !== 1'b0 || got_q.size() != 0) begin
            n_fail++; $display("FAIL partial output: got valid=%b words=%0d expected valid=0 words=0", rx_valid, got_q.size());
        end
        err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL partial err_clr: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
    endtask

    task automatic test_long();
        clear_state();
        rx_ready = 1'b1;
        din = 1'b1; step(100);
        din = 1'b0; step(1300);
        send_word(24'h5A5A5A, BITS);
        latch_gap();
        step(5);
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0100) begin
            n_fail++; $display("FAIL long errors: got %b expected 0100", {err_glitch, err_long, err_partial, err_ovf});
        end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL long count: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== 24'h5A5A5A) begin
            n_fail++; $display("FAIL long word: got %h expected 5a5a5a", got_q[0]);
        end
        n_checks++;
        if (fe_cnt != 2) begin n_fail++; $display("FAIL long frame_end count: got %0d expected 2", fe_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_state();
        rx_ready = 1'b1;
        send_word(24'hFFC000, 10);
        reset = 1'b0;
        step(2);
        n_checks++;
        if ({rx_data, rx_valid, frame_end, err_glitch, err_long, err_partial, err_ovf} !== '0) begin
            n_fail++; $display("FAIL reset_mid outputs: got data=%h valid=%b fe=%b errs=%b expected all 0",
                               rx_data, rx_valid, frame_end, {err_glitch, err_long, err_partial, err_ovf});
        end
        reset = 1'b1;
        step(2);
        got_q.delete();
        fe_cnt = 0;
        send_word(24'h800000, BITS);
        latch_gap();
        step(5);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL reset_mid count: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== 24'h800000) begin
            n_fail++; $display("FAIL reset_mid word: got %h expected 800000", got_q[0]);
        end
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid errors: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
    endtask

    task automatic test_enable();
        clear_state();
        rx_ready = 1'b0;
        send_word(24'h0F0F0F, BITS);
        send_word(24'hFFC000, 10);
        enable = 1'b0;
        step(20);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 24'h0F0F0F) begin
            n_fail++; $display("FAIL enable kept word: got valid=%b data=%h expected valid=1 data=0f0f0f", rx_valid, rx_data);
        end
        din = 1'b1; step(5);
        enable = 1'b1; step(10);
        din = 1'b0; step(20);
        rx_ready = 1'b1;
        send_word(24'hC3C3C3, BITS);
        latch_gap();
        step(5);
        exp_q.push_back(24'h0F0F0F);
        exp_q.push_back(24'hC3C3C3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL enable count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL enable word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL enable errors: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
        n_checks++;
        if (fe_cnt != 1) begin n_fail++; $display("FAIL enable frame_end count: got %0d expected 1", fe_cnt); end
    endtask

    // Random pulse widths across the whole legal range, with boundary widths mixed in;
    // the expected bit is purely the rule "high >= T_THRESH decodes 1".
    task automatic test_random();
        int bl [4];
        int hi, lo;
        logic [BITS-1:0] w;
        bl = '{3, 14, 15, 39};
        clear_state();
        rand_ready_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            w = '0;
            for (int b = 0; b < BITS; b++) begin
                if ($urandom_range(0, 3) == 0) hi = bl[$urandom_range(0, 3)];
                else                           hi = $urandom_range(3, 39);
                lo = $urandom_range(5, 40);
                w = (w << 1) | BITS'(hi >= T_THRESH);
                send_bit(1'b0, hi, lo);
            end
            exp_q.push_back(w);
        end
        rand_ready_en = 1'b0;
        rx_ready = 1'b1;
        latch_gap();
        step(5);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        n_checks++;
        if ({err_glitch, err_long, err_partial, err_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL random errors: got %b expected 0000", {err_glitch, err_long, err_partial, err_ovf});
        end
        n_checks++;
        if (fe_cnt != 1) begin n_fail++; $display("FAIL random frame_end count: got %0d expected 1", fe_cnt); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_partial();
        test_long();
        test_reset_mid();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
